// File: rtl/button_repeat_scheduler.sv
// Shared hold-to-repeat timer for N debounced buttons. Press and repeat
// events are merged onto a single valid/ready event stream.
module button_repeat_scheduler #(
    parameter int unsigned N_BUTTONS    = 4,
    parameter int unsigned TICK_DIV     = 15,
    parameter int unsigned WAIT_TICKS   = 48,
    parameter int unsigned REPEAT_TICKS = 8,
    localparam int unsigned ID_W        = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic [N_BUTTONS-1:0] i_buttons,
    output logic                 o_event_valid,
    output logic [ID_W-1:0]      o_event_id,
    output logic                 o_event_repeat,
    input  logic                 i_event_ready,
    output logic                 o_repeat_active,
    output logic [ID_W-1:0]      o_owner_id
);

    localparam int unsigned WAIT_W = $clog2(WAIT_TICKS + 1);
    localparam int unsigned REP_W  = $clog2(REPEAT_TICKS + 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_TICKS - 1);
    localparam logic [REP_W-1:0]  LAST_REP  = REP_W'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [TICK_DIV-1:0]    prescaler;
    logic [N_BUTTONS-1:0]   prev_buttons;
    logic [N_BUTTONS-1:0]   press_pending, press_pending_next;
    logic                   repeat_pending, repeat_pending_next;
    logic [ID_W-1:0]        owner, owner_next;
    logic [WAIT_W-1:0]      wait_cnt, wait_cnt_next;
    logic [REP_W-1:0]       rep_cnt, rep_cnt_next;
    logic                   ev_valid_next;
    logic [ID_W-1:0]        ev_id_next;
    logic                   ev_repeat_next;

    logic                   tick_c;
    logic [N_BUTTONS-1:0]   rise_c;
    logic                   any_btn_c;
    logic [ID_W-1:0]        low_btn_c;
    logic                   owner_held_c;
    logic                   press_any_c;
    logic [ID_W-1:0]        press_sel_c;
    logic [N_BUTTONS-1:0]   press_onehot_c;
    logic [N_BUTTONS-1:0]   press_clr_c;
    logic                   repeat_clr_c;
    logic                   repeat_set_c;
    logic                   release_c;
    logic                   load_c;

    assign tick_c    = &prescaler;
    assign rise_c    = i_buttons & ~prev_buttons;
    assign any_btn_c = |i_buttons;

    // Lowest held button, and whether the current owner is still held.
    always_comb begin
        low_btn_c    = '0;
        owner_held_c = 1'b0;
        for (int k = int'(N_BUTTONS) - 1; k >= 0; k--) begin
            if (i_buttons[k]) begin
                low_btn_c = ID_W'(k);
            end
            if (owner == ID_W'(k)) begin
                owner_held_c = i_buttons[k];
            end
        end
    end

    // Lowest pending press, as an index and as a one-hot clear mask.
    always_comb begin
        press_any_c    = |press_pending;
        press_sel_c    = '0;
        press_onehot_c = '0;
        for (int k = int'(N_BUTTONS) - 1; k >= 0; k--) begin
            if (press_pending[k]) begin
                press_sel_c    = ID_W'(k);
                press_onehot_c = '0;
                press_onehot_c[k] = 1'b1;
            end
        end
    end

    // Timer FSM next state: owner selection, tick counting, release handling.
    always_comb begin
        state_next    = state;
        owner_next    = owner;
        wait_cnt_next = wait_cnt;
        rep_cnt_next  = rep_cnt;
        repeat_set_c  = 1'b0;
        release_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_btn_c) begin
                    owner_next    = low_btn_c;
                    wait_cnt_next = '0;
                    rep_cnt_next  = '0;
                    state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!owner_held_c) begin
                    release_c = 1'b1;
                end else if (tick_c) begin
                    wait_cnt_next = wait_cnt + WAIT_W'(1);
                    if (wait_cnt == LAST_WAIT) begin
                        state_next   = ST_REPEAT;
                        repeat_set_c = 1'b1;
                        rep_cnt_next = '0;
                    end
                end
            end
            ST_REPEAT: begin
                if (!owner_held_c) begin
                    release_c = 1'b1;
                end else if (tick_c) begin
                    if (rep_cnt == LAST_REP) begin
                        repeat_set_c = 1'b1;
                        rep_cnt_next = '0;
                    end else begin
                        rep_cnt_next = rep_cnt + REP_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (release_c) begin
            state_next    = ST_IDLE;
            owner_next    = '0;
            wait_cnt_next = '0;
            rep_cnt_next  = '0;
        end
    end

    // Event register load: presses beat repeats, lowest index first.
    always_comb begin
        load_c         = !o_event_valid || i_event_ready;
        ev_valid_next  = o_event_valid;
        ev_id_next     = o_event_id;
        ev_repeat_next = o_event_repeat;
        press_clr_c    = '0;
        repeat_clr_c   = 1'b0;
        if (load_c) begin
            if (press_any_c) begin
                ev_valid_next  = 1'b1;
                ev_id_next     = press_sel_c;
                ev_repeat_next = 1'b0;
                press_clr_c    = press_onehot_c;
            end else if (repeat_pending) begin
                ev_valid_next  = 1'b1;
                ev_id_next     = owner;
                ev_repeat_next = 1'b1;
                repeat_clr_c   = 1'b1;
            end else begin
                ev_valid_next  = 1'b0;
            end
        end
    end

    // Pending flags: a new set in the same cycle wins over the load clear.
    always_comb begin
        press_pending_next = (press_pending & ~press_clr_c) | rise_c;
        if (repeat_set_c) begin
            repeat_pending_next = 1'b1;
        end else if (release_c || repeat_clr_c) begin
            repeat_pending_next = 1'b0;
        end else begin
            repeat_pending_next = repeat_pending;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= ST_IDLE;
            prescaler       <= '0;
            prev_buttons    <= '0;
            press_pending   <= '0;
            repeat_pending  <= 1'b0;
            owner           <= '0;
            wait_cnt        <= '0;
            rep_cnt         <= '0;
            o_event_valid   <= 1'b0;
            o_event_id      <= '0;
            o_event_repeat  <= 1'b0;
            o_repeat_active <= 1'b0;
            o_owner_id      <= '0;
        end else begin
            state           <= state_next;
            prescaler       <= prescaler + TICK_DIV'(1);
            prev_buttons    <= i_buttons;
            press_pending   <= press_pending_next;
            repeat_pending  <= repeat_pending_next;
            owner           <= owner_next;
            wait_cnt        <= wait_cnt_next;
            rep_cnt         <= rep_cnt_next;
            o_event_valid   <= ev_valid_next;
            o_event_id      <= ev_id_next;
            o_event_repeat  <= ev_repeat_next;
            o_repeat_active <= (state_next == ST_REPEAT);
            o_owner_id      <= owner_next;
        end
    end

endmodule

// File: tb/tb_button_repeat_scheduler.sv
// Bench for button_repeat_scheduler: fixed vector table, directed corner
// sequences and random traffic against a tick-count reference model.
module tb_button_repeat_scheduler;

    localparam int NB     = 4;
    localparam int WAIT_T = 3;
    localparam int REP_T  = 2;
    localparam int TPER   = 4;   // clocks per tick with TICK_DIV = 2

    logic          i_clock = 1'b0;
    logic          i_reset_n;
    logic [NB-1:0] i_buttons;
    logic          i_event_ready;
    logic          o_event_valid;
    logic [1:0]    o_event_id;
    logic          o_event_repeat;
    logic          o_repeat_active;
    logic [1:0]    o_owner_id;

    button_repeat_scheduler #(
        .N_BUTTONS   (NB),
        .TICK_DIV    (2),
        .WAIT_TICKS  (WAIT_T),
        .REPEAT_TICKS(REP_T)
    ) dut (
        .i_clock        (i_clock),
        .i_reset_n      (i_reset_n),
        .i_buttons      (i_buttons),
        .o_event_valid  (o_event_valid),
        .o_event_id     (o_event_id),
        .o_event_repeat (o_event_repeat),
        .i_event_ready  (i_event_ready),
        .o_repeat_active(o_repeat_active),
        .o_owner_id     (o_owner_id)
    );

    always #5 i_clock = ~i_clock;

    int vectors    = 0;
    int miscompares = 0;
    int stepno     = 0;

    // Reference model: time measured in ticks since the owner started waiting.
    int            m_cyc;
    logic [NB-1:0] m_prev;
    logic [NB-1:0] m_pp;
    bit            m_rp;
    bit            m_own_v;
    int            m_owner;
    int            m_ticks;
    bit            m_v;
    int            m_id;
    bit            m_rep;

    typedef struct {
        int id;
        bit rep;
        int t;
    } ev_t;
    ev_t acc[$];

    typedef struct {
        logic [NB-1:0] btn;
        bit            rdy;
        bit            v;
        int            id;
        bit            rep;
        bit            act;
        int            own;
    } vec_t;
    vec_t tbl[$];

    function automatic int lowest(input logic [NB-1:0] b);
        for (int i = 0; i < NB; i++) if (b[i]) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_cyc = 0; m_prev = '0; m_pp = '0; m_rp = 0;
        m_own_v = 0; m_owner = 0; m_ticks = 0;
        m_v = 0; m_id = 0; m_rep = 0;
    endfunction

    function automatic void model_edge(input logic [NB-1:0] btn, input bit rdy);
        bit            tick;
        logic [NB-1:0] pp;
        bit            rp;
        int            k;
        tick = (m_cyc % TPER) == TPER - 1;
        pp = m_pp;
        rp = m_rp;
        if (!m_v || rdy) begin
            if (pp != 0) begin
                k = lowest(pp);
                m_v = 1; m_id = k; m_rep = 0; pp[k] = 1'b0;
            end else if (rp) begin
                m_v = 1; m_id = m_owner; m_rep = 1; rp = 0;
            end else begin
                m_v = 0;
            end
        end
        if (!m_own_v) begin
            if (btn != 0) begin
                m_own_v = 1; m_owner = lowest(btn); m_ticks = 0;
            end
        end else if (!btn[m_owner]) begin
            m_own_v = 0; m_owner = 0; m_ticks = 0; rp = 0;
        end else if (tick) begin
            m_ticks++;
            if (m_ticks >= WAIT_T && ((m_ticks - WAIT_T) % REP_T) == 0) rp = 1;
        end
        m_pp   = pp | (btn & ~m_prev);
        m_rp   = rp;
        m_prev = btn;
        m_cyc++;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        bit bad;
        bit e_act;
        int e_own;
        bad   = 0;
        e_act = m_own_v && (m_ticks >= WAIT_T);
        e_own = m_own_v ? m_owner : 0;
        if (o_event_valid !== m_v) bad = 1;
        if (m_v && (int'(o_event_id) != m_id || o_event_repeat !== m_rep)) bad = 1;
        if (o_repeat_active !== e_act) bad = 1;
        if (int'(o_owner_id) != e_own) bad = 1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL model step %0d: got v=%0b id=%0d rep=%0b act=%0b own=%0d, expected v=%0b id=%0d rep=%0b act=%0b own=%0d",
                     stepno, o_event_valid, o_event_id, o_event_repeat, o_repeat_active, o_owner_id,
                     m_v, m_id, m_rep, e_act, e_own);
        end
    endtask

    // Apply one clock of stimulus from the falling edge, check after the next one.
    task automatic step(input logic [NB-1:0] btn, input bit rdy);
        if (o_event_valid && rdy)
            acc.push_back('{id: int'(o_event_id), rep: o_event_repeat, t: stepno});
        i_buttons     = btn;
        i_event_ready = rdy;
        model_edge(btn, rdy);
        @(posedge i_clock);
        @(negedge i_clock);
        stepno++;
        check_model();
    endtask

    function automatic void add(input logic [NB-1:0] btn, input bit rdy, input bit v,
                                input int id, input bit rep, input bit act, input int own,
                                input int n);
        for (int i = 0; i < n; i++)
            tbl.push_back('{btn: btn, rdy: rdy, v: v, id: id, rep: rep, act: act, own: own});
    endfunction

    function automatic int count_ev(input int id, input bit rep);
        int c;
        c = 0;
        foreach (acc[i]) if (acc[i].id == id && acc[i].rep == rep) c++;
        return c;
    endfunction

    initial begin
        int            n;
        int            held_id;
        bit            held_rep;
        int            unstable;
        int            nv;
        bit            ok;
        logic [NB-1:0] rb;

        // Single hold of button 2 from reset, cycle-exact expectations.
        add(4'b0100, 1, 0, 0, 0, 0, 2, 1);
        add(4'b0100, 1, 1, 2, 0, 0, 2, 1);
        add(4'b0100, 1, 0, 0, 0, 0, 2, 9);
        add(4'b0100, 1, 0, 0, 0, 1, 2, 1);
        add(4'b0100, 1, 1, 2, 1, 1, 2, 1);
        add(4'b0100, 1, 0, 0, 0, 1, 2, 7);
        add(4'b0100, 1, 1, 2, 1, 1, 2, 1);
        add(4'b0000, 1, 0, 0, 0, 0, 0, 4);

        i_reset_n = 1'b0;
        i_buttons = '0;
        i_event_ready = 1'b0;
        model_reset();
        #23;
        chk("reset_valid", int'(o_event_valid), 0);
        chk("reset_owner", int'(o_owner_id), 0);
        chk("reset_active", int'(o_repeat_active), 0);
        @(negedge i_clock);
        i_reset_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].btn, tbl[i].rdy);
            vectors++;
            if (o_event_valid !== tbl[i].v ||
                (tbl[i].v && (int'(o_event_id) != tbl[i].id || o_event_repeat !== tbl[i].rep)) ||
                o_repeat_active !== tbl[i].act || int'(o_owner_id) != tbl[i].own) begin
                miscompares++;
                $display("FAIL table row %0d: got v=%0b id=%0d rep=%0b act=%0b own=%0d, expected v=%0b id=%0d rep=%0b act=%0b own=%0d",
                         i, o_event_valid, o_event_id, o_event_repeat, o_repeat_active, o_owner_id,
                         tbl[i].v, tbl[i].id, tbl[i].rep, tbl[i].act, tbl[i].own);
            end
        end

        // Simultaneous press of buttons 1 and 3, then hand-over to 3.
        acc.delete();
        for (int i = 0; i < 4; i++) step(4'b1010, 1);
        ok = acc.size() == 2 && acc[0].id == 1 && !acc[0].rep &&
             acc[1].id == 3 && !acc[1].rep && acc[1].t == acc[0].t + 1;
        chk("simul_press_order", int'(ok), 1);
        chk("simul_owner", int'(o_owner_id), 1);
        step(4'b1000, 1);
        chk("handover_idle_owner", int'(o_owner_id), 0);
        step(4'b1000, 1);
        chk("handover_owner", int'(o_owner_id), 3);
        acc.delete();
        for (int i = 0; i < 20; i++) step(4'b1000, 1);
        ok = acc.size() > 0 && acc[0].id == 3 && acc[0].rep;
        chk("handover_first_repeat", int'(ok), 1);
        chk("handover_no_press", count_ev(3, 0), 0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1);

        // Backpressure during REPEAT on button 0: fields hold, repeats coalesce.
        n = 0;
        while (!o_repeat_active && n < 40) begin step(4'b0001, 1); n++; end
        chk("bp_enter_repeat", int'(o_repeat_active), 1);
        n = 0;
        step(4'b0001, 0);
        while (!o_event_valid && n < 20) begin step(4'b0001, 0); n++; end
        chk("bp_valid_held", int'(o_event_valid), 1);
        held_id  = int'(o_event_id);
        held_rep = o_event_repeat;
        chk("bp_held_event", held_id * 2 + int'(held_rep), 1);
        unstable = 0;
        for (int i = 0; i < 40; i++) begin
            step(4'b0001, 0);
            if (!o_event_valid || int'(o_event_id) != held_id || o_event_repeat != held_rep)
                unstable++;
        end
        chk("bp_stable", unstable, 0);
        acc.delete();
        step(4'b0001, 1);
        step(4'b0001, 1);
        chk("bp_drain_count", count_ev(0, 1), 2);
        chk("bp_drain_total", acc.size(), 2);
        for (int i = 0; i < 3; i++) step(4'b0000, 1);

        // Early release of button 1 during WAIT, then a fresh press.
        acc.delete();
        n = 0;
        step(4'b0010, 1);
        while (!(m_own_v && m_ticks == 2) && n < 20) begin step(4'b0010, 1); n++; end
        chk("early_two_ticks", m_ticks, 2);
        for (int i = 0; i < 4; i++) step(4'b0000, 1);
        chk("early_no_repeat", count_ev(1, 1), 0);
        chk("early_press_once", count_ev(1, 0), 1);
        acc.delete();
        for (int i = 0; i < 10; i++) step(4'b0010, 1);
        chk("repress_event", count_ev(1, 0), 1);
        chk("repress_no_early_repeat", count_ev(1, 1), 0);
        for (int i = 0; i < 8; i++) step(4'b0010, 1);
        chk("repress_repeat_arrives", int'(count_ev(1, 1) > 0), 1);

        // Press of button 0 while a button-1 repeat is queued behind backpressure.
        n = 0;
        while (!o_repeat_active && n < 40) begin step(4'b0010, 1); n++; end
        n = 0;
        step(4'b0010, 0);
        while (!o_event_valid && n < 20) begin step(4'b0010, 0); n++; end
        for (int i = 0; i < 20; i++) step(4'b0010, 0);
        step(4'b0011, 0);
        step(4'b0011, 0);
        acc.delete();
        for (int i = 0; i < 3; i++) step(4'b0011, 1);
        ok = acc.size() == 3 && acc[0].id == 1 && acc[0].rep &&
             acc[1].id == 0 && !acc[1].rep && acc[2].id == 1 && acc[2].rep;
        chk("press_before_repeat", int'(ok), 1);
        chk("no_preempt_owner", int'(o_owner_id), 1);
        for (int i = 0; i < 3; i++) step(4'b0000, 1);

        // Asynchronous reset mid-REPEAT with an event held.
        n = 0;
        while (!o_repeat_active && n < 40) begin step(4'b0100, 1); n++; end
        n = 0;
        step(4'b0100, 0);
        while (!o_event_valid && n < 20) begin step(4'b0100, 0); n++; end
        chk("pre_reset_valid", int'(o_event_valid), 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("async_reset_valid", int'(o_event_valid), 0);
        chk("async_reset_active", int'(o_repeat_active), 0);
        chk("async_reset_owner", int'(o_owner_id), 0);
        i_buttons = '0;
        model_reset();
        @(negedge i_clock);
        i_reset_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 64; i++) begin
            step(4'b0000, 1);
            if (o_event_valid) nv++;
        end
        chk("quiet_after_reset", nv, 0);

        // Random traffic against the model.
        rb = '0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 11) == 0) rb[$urandom_range(0, NB - 1)] ^= 1'b1;
            step(rb, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
